maxpool_bin_mc: RTL
===================

Name: maxpool_bin_mc

Overview:
- Streaming multi-channel binary pooling block that follows the binary conv layers. It performs non-overlapping KxK max (OR) or min (AND) pooling over a raster-order feature map.
- Each pixel carries CHANNELS bits, one per feature map, and all channels are pooled in parallel.
- Valid/ready handshakes on input and output allow back-pressure from the next layer. A frame_done pulse marks the last pooled pixel of each frame.

Parameters:
- IN_WIDTH, 26, input columns per row (>= POOL_K).
- IN_HEIGHT, 26, input rows per frame (>= POOL_K).
- CHANNELS, 8, bits per pixel (>= 1).
- POOL_K, 2, window size and stride (2..4).
- Derived: OUT_W = IN_WIDTH/POOL_K and OUT_H = IN_HEIGHT/POOL_K (floor division).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- pool_mode  in  1  0 = max (OR), 1 = min (AND); latched at the first accepted pixel of each frame.
- valid_in  in  1  input pixel valid.
- ready_in  out  1  block can accept a pixel.
- pixel_in  in  CHANNELS  input pixel, bit c = channel c.
- valid_out  out  1  pooled pixel valid.
- ready_out  in  1  downstream accepts the pooled pixel.
- pixel_out  out  CHANNELS  pooled pixel.
- frame_done  out  1  high together with valid_out on the final pooled pixel of a frame (index OUT_W*OUT_H-1).

Behaviour:
- Reset (asynchronous, reset=0) clears:
  - all counters;
  - valid_out=0, pixel_out=0, frame_done=0;
  - the accumulator array;
  - the latched mode, to 0.
  - ready_in is combinational, so it reads 1 during and after reset.
- Accept: a pixel is accepted when valid_in && ready_in. ready_in = !valid_out || ready_out. An unaccepted pixel leaves all state unchanged.
- Counters:
  - col (0..IN_WIDTH-1) and row (0..IN_HEIGHT-1) advance on each accept.
  - col wraps at IN_WIDTH-1 and increments row. row wraps at IN_HEIGHT-1, which ends the frame.
  - Derived: window column wc = col mod POOL_K, window row wr = row mod POOL_K, output column oc = col / POOL_K.
- Accumulator: array acc[0..OUT_W-1] of CHANNELS bits.
  - For an in-region pixel (col < OUT_W*POOL_K and row < OUT_H*POOL_K):
    - If wr==0 && wc==0: comb = pixel_in.
    - Otherwise: comb = acc[oc] OR pixel_in (mode 0), or acc[oc] AND pixel_in (mode 1).
    - Write comb to acc[oc].
  - Out-of-region pixels (the floor-division remainder in trailing columns/rows) are accepted and discarded; they do not affect acc or output.
- Emit: when an in-region pixel with wr==POOL_K-1 and wc==POOL_K-1 is accepted:
  - next cycle: valid_out=1 and pixel_out=comb;
  - frame_done=1 if this is the last pooled pixel of the frame.
  - Latency is 1 cycle from the accepting edge.
- Output hold: while valid_out && !ready_out, pixel_out, valid_out and frame_done hold steady and ready_in=0.
  - On ready_out=1 with no new emit, valid_out and frame_done clear next cycle.
  - Simultaneous drain and new emit: the output register loads the new value and valid_out stays 1 with no bubble.
- Mode: pool_mode is sampled at an accept with row==0 && col==0 and used for the whole frame. Changes mid-frame are ignored.
- Frame wrap: after the last input pixel, counters return to 0 and the next frame starts immediately with no idle cycle required.
- Reset mid-frame: the partial window is discarded, any pending output is dropped, and the next accepted pixel is treated as row 0, col 0.
- Throughput: 1 pixel/cycle when ready_out is held 1.

Test Plan:
- IN 4x4, CH=2, K=2, mode 0. Channel0 has a single 1 at (row 1, col 2); channel1 all 0; ready_out=1, valid_in every cycle. Outputs appear 1 cycle after the inputs at (1,1), (1,3), (3,1), (3,3): 2'b00, 2'b01, 2'b00, 2'b00. frame_done=1 on the 4th output only.
- Same frame in mode 1 with channel0 all 1 except (2,0)=0. Outputs are 2'b01, 2'b01, 2'b00, 2'b01, showing AND pooling.
- IN 5x5, K=2, mode 0. Column 4 and row 4 are driven all 1s, with zeros elsewhere. Exactly 4 outputs, all 0; the remainder pixels are ignored and frame_done is still asserted on the 4th output.
- Back-pressure: hold ready_out=0 when the first output appears. valid_out and pixel_out stay stable for 5 cycles and ready_in=0. Release ready_out: valid_out clears on the next edge unless a new emit coincides; with a coinciding emit, valid_out stays 1 and pixel_out updates.
- Mode latch: toggle pool_mode mid-frame. Output matches the mode sampled at (0,0). The next frame uses the new mode.
- Assert reset for 1 cycle after 6 pixels of a 4x4 frame, then send a full frame. The first output reflects only post-reset pixels, and there is no stale valid_out.

Source files
------------

// File: rtl/maxpool_bin_mc.sv
// Streaming multi-channel binary KxK pooling (OR = max, AND = min) over a raster-order
// feature map, with valid/ready handshakes on both sides and an end-of-frame marker.
module maxpool_bin_mc #(
  parameter int IN_WIDTH  = 26,
  parameter int IN_HEIGHT = 26,
  parameter int CHANNELS  = 8,
  parameter int POOL_K    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pool_mode,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [CHANNELS-1:0] pixel_in,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [CHANNELS-1:0] pixel_out,
  output logic                frame_done
);

  localparam int OUT_W = IN_WIDTH / POOL_K;
  localparam int OUT_H = IN_HEIGHT / POOL_K;
  localparam int CW    = $clog2(IN_WIDTH);
  localparam int RW    = $clog2(IN_HEIGHT);
  localparam int KW    = $clog2(POOL_K);
  localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0] COL_LAST    = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(IN_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST_IN = CW'(OUT_W * POOL_K - 1);
  localparam logic [RW-1:0] ROW_LAST_IN = RW'(OUT_H * POOL_K - 1);
  localparam logic [KW-1:0] K_LAST      = KW'(POOL_K - 1);
  localparam logic [AW-1:0] OC_LAST     = AW'(OUT_W - 1);

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [KW-1:0]       wc;
  logic [KW-1:0]       wr;
  logic [AW-1:0]       oc;
  logic                mode_q;
  logic [CHANNELS-1:0] acc [OUT_W];

  logic                accept;
  logic                frame_start;
  logic                in_region;
  logic                win_start;
  logic                win_end;
  logic                last_pos;
  logic                emit;
  logic [CHANNELS-1:0] comb;

  assign ready_in    = !valid_out || ready_out;
  assign accept      = valid_in && ready_in;
  assign frame_start = (col == '0) && (row == '0);
  assign in_region   = (col <= COL_LAST_IN) && (row <= ROW_LAST_IN);
  assign win_start   = (wc == '0) && (wr == '0);
  assign win_end     = (wc == K_LAST) && (wr == K_LAST);
  assign last_pos    = (col == COL_LAST_IN) && (row == ROW_LAST_IN);
  assign emit        = accept && in_region && win_end;

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    comb = pixel_in;
    if (!win_start) begin
      comb = mode_q ? (acc[oc] & pixel_in) : (acc[oc] | pixel_in);
    end
  end

  // Raster position plus incremental window/output-column indices, avoiding a
  // divider; oc saturates so remainder columns never index past the array.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
      wc  <= '0;
      wr  <= '0;
      oc  <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        wc  <= '0;
        oc  <= '0;
        if (row == ROW_LAST) begin
          row <= '0;
          wr  <= '0;
        end else begin
          row <= row + 1'b1;
          wr  <= (wr == K_LAST) ? '0 : wr + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        wc  <= (wc == K_LAST) ? '0 : wc + 1'b1;
        if (wc == K_LAST && oc != OC_LAST) begin
          oc <= oc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= 1'b0;
    end else if (accept && frame_start) begin
      mode_q <= pool_mode;
    end
  end

  // NOTE: the accumulator row is small and must read as zero after reset, so it is
  // built from resettable flops rather than an unreset RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < OUT_W; i++) begin
        acc[i] <= '0;
      end
    end else if (accept && in_region) begin
      acc[oc] <= comb;
    end
  end

  // A new emit takes priority over draining, so a simultaneous drain and load keeps
  // valid_out high without a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out  <= 1'b0;
      pixel_out  <= '0;
      frame_done <= 1'b0;
    end else if (emit) begin
      valid_out  <= 1'b1;
      pixel_out  <= comb;
      frame_done <= last_pos;
    end else if (ready_out) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule
